// File: rtl/async_bus_target.sv
// rtl/async_bus_target.sv - slave responder for the async CS/RD/WR 16-bit parallel bus
//
// Purpose:
//   Answers the CPU-side bridge's asynchronous chip-select/read/write bus on
//   behalf of an FPGA-internal peripheral. Each bus strobe pulse becomes
//   exactly one request/ready transaction on the local register port; read
//   data is driven back with an explicit output enable.
//
// Optional feature (macro ASYNC_BUS_TARGET_WAIT_EN):
//   When defined, adds output bus_waitn, low while a local request is
//   outstanding so the host can stretch its cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus_csn/rdn/wrn async active-low chip select / read / write strobes
//   bus_a, bus_din  word address and write data from host (sampled at capture)
//   bus_dout,bus_oe read data and pin output enable toward host
//   loc_valid/we/addr/wdata  local request (held stable while loc_valid=1)
//   loc_rdata,loc_ready      local completion
//   proto_err       sticky protocol-error flag, cleared by reset only
//   bus_waitn       (optional) 0 = host must extend the access

module async_bus_target #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_csn,
    input  logic              bus_rdn,
    input  logic              bus_wrn,
    input  logic [ADDR_W-1:0] bus_a,
    input  logic [15:0]       bus_din,
    output logic [15:0]       bus_dout,
    output logic              bus_oe,
    output logic              loc_valid,
    output logic              loc_we,
    output logic [ADDR_W-1:0] loc_addr,
    output logic [15:0]       loc_wdata,
    input  logic [15:0]       loc_rdata,
    input  logic              loc_ready,
    output logic              proto_err
`ifdef ASYNC_BUS_TARGET_WAIT_EN
    ,
    output logic              bus_waitn
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_RD_REQ   = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_WAIT_END = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Chip select is only used as a level, so it needs no history flop.
    // Read/write strobes keep a third flop for falling-edge detection.
    logic [1:0] csn_sync_q;
    logic [2:0] rdn_sync_q;
    logic [2:0] wrn_sync_q;

    logic cs_s, rd_s, wr_s;
    logic rd_fall, wr_fall, any_fall;

    logic [15:0]       bus_dout_q, bus_dout_d;
    logic              bus_oe_q, bus_oe_d;
    logic              loc_valid_q, loc_valid_d;
    logic              loc_we_q, loc_we_d;
    logic [ADDR_W-1:0] loc_addr_q, loc_addr_d;
    logic [15:0]       loc_wdata_q, loc_wdata_d;
    logic              proto_err_q, proto_err_d;

    assign cs_s = csn_sync_q[1];
    assign rd_s = rdn_sync_q[1];
    assign wr_s = wrn_sync_q[1];

    assign rd_fall  = rdn_sync_q[2] & ~rdn_sync_q[1];
    assign wr_fall  = wrn_sync_q[2] & ~wrn_sync_q[1];
    // Edges seen while deselected belong to some other target.
    assign any_fall = (rd_fall | wr_fall) & ~cs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_sync_q <= 2'b11;
            rdn_sync_q <= 3'b111;
            wrn_sync_q <= 3'b111;
        end else begin
            csn_sync_q <= {csn_sync_q[0], bus_csn};
            rdn_sync_q <= {rdn_sync_q[1:0], bus_rdn};
            wrn_sync_q <= {wrn_sync_q[1:0], bus_wrn};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_dout_q  <= 16'h0000;
            bus_oe_q    <= 1'b0;
            loc_valid_q <= 1'b0;
            loc_we_q    <= 1'b0;
            loc_addr_q  <= '0;
            loc_wdata_q <= 16'h0000;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_dout_q  <= bus_dout_d;
            bus_oe_q    <= bus_oe_d;
            loc_valid_q <= loc_valid_d;
            loc_we_q    <= loc_we_d;
            loc_addr_q  <= loc_addr_d;
            loc_wdata_q <= loc_wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_dout_d  = bus_dout_q;
        bus_oe_d    = bus_oe_q;
        loc_valid_d = loc_valid_q;
        loc_we_d    = loc_we_q;
        loc_addr_d  = loc_addr_q;
        loc_wdata_d = loc_wdata_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    if (wr_fall) begin
                        // bus_a/bus_din are stable by the time the strobe has
                        // crossed the synchronizer, so they are taken raw here.
                        loc_addr_d  = bus_a;
                        loc_wdata_d = bus_din;
                        loc_we_d    = 1'b1;
                        loc_valid_d = 1'b1;
                        state_d     = ST_WR_REQ;
                        if (!rd_s) begin
                            proto_err_d = 1'b1;
                        end
                    end else if (rd_fall) begin
                        loc_addr_d  = bus_a;
                        loc_we_d    = 1'b0;
                        loc_valid_d = 1'b1;
                        state_d     = ST_RD_REQ;
                        if (!wr_s) begin
                            proto_err_d = 1'b1;
                        end
                    end
                end
            end

            ST_WR_REQ: begin
                if (loc_ready) begin
                    loc_valid_d = 1'b0;
                    state_d     = ST_WAIT_END;
                end
            end

            ST_RD_REQ: begin
                if (loc_ready) begin
                    loc_valid_d = 1'b0;
                    bus_dout_d  = loc_rdata;
                    if (!cs_s && !rd_s) begin
                        bus_oe_d = 1'b1;
                        state_d  = ST_RD_DRIVE;
                    end else begin
                        // Host gave up before data arrived; never drive pins.
                        state_d = ST_WAIT_END;
                    end
                end
            end

            ST_RD_DRIVE: begin
                if (cs_s || rd_s) begin
                    bus_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_WAIT_END: begin
                // Wait out the current strobe so one pulse = one transaction.
                if ((rd_s && wr_s) || cs_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && any_fall) begin
            proto_err_d = 1'b1;
        end
    end

    assign bus_dout  = bus_dout_q;
    assign bus_oe    = bus_oe_q;
    assign loc_valid = loc_valid_q;
    assign loc_we    = loc_we_q;
    assign loc_addr  = loc_addr_q;
    assign loc_wdata = loc_wdata_q;
    assign proto_err = proto_err_q;

`ifdef ASYNC_BUS_TARGET_WAIT_EN
    assign bus_waitn = !((state_q == ST_WR_REQ) ||
                         ((state_q == ST_RD_REQ) && loc_valid_q));
`endif

endmodule
